// File: rtl/msx_ram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | msx_ram_port_arbiter: shares one 8-bit RAM port between CPU, flash       |
// | emulation and block loader.                         Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module msx_ram_port_arbiter #(
  parameter int AW        = 27,
  parameter int CPU_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic [7:0]    p0_din,
  input  logic          p0_rnw,
  output logic          p0_done,
  output logic [7:0]    p0_dout,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic [7:0]    p1_din,
  input  logic          p1_rnw,
  output logic          p1_done,
  output logic [7:0]    p1_dout,
  input  logic          p2_req,
  input  logic [AW-1:0] p2_addr,
  input  logic [7:0]    p2_din,
  input  logic          p2_rnw,
  output logic          p2_done,
  output logic [7:0]    p2_dout,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_rnw,
  input  logic          mem_ack,
  input  logic          mem_done,
  input  logic [7:0]    mem_dout,
  output logic          timeout_err
);

  localparam int BW = $clog2(CPU_BURST + 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      grant_oh;
  logic [2:0]      sel_oh;
  logic            grant;
  logic            bg_pend;
  logic            force_bg;
  logic            finish;
  logic            abort;
  logic            rr_p2;
  logic [BW-1:0]   burst_cnt;
  logic [7:0]      tmo_cnt;
  logic [AW-1:0]   grant_addr;
  logic [7:0]      grant_din;
  logic            grant_rnw;
  logic [2:0]      done;
  logic [7:0]      dout [3];

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_oh   = 3'b000;
    bg_pend    = p1_req | p2_req;
    force_bg   = bg_pend && (burst_cnt == BW'(CPU_BURST));
    finish     = ((state == ISSUE) && mem_ack && mem_done) ||
                 ((state == WAIT_DONE) && mem_done);
    abort      = !finish && (state != IDLE) && (tmo_cnt == 8'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (p0_req && !force_bg) begin
          grant    = 1'b1;
          grant_oh = 3'b001;
        end else if (bg_pend) begin
          grant = 1'b1;
          // Round-robin: pointer names the background port preferred next
          if (rr_p2) grant_oh = p2_req ? 3'b100 : 3'b010;
          else       grant_oh = p1_req ? 3'b010 : 3'b100;
        end
        if (grant) state_nx = ISSUE;
      end
      ISSUE: begin
        if (finish || abort) state_nx = IDLE;
        else if (mem_ack)    state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (finish || abort) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    grant_addr = grant_oh[0] ? p0_addr : (grant_oh[1] ? p1_addr : p2_addr);
    grant_din  = grant_oh[0] ? p0_din  : (grant_oh[1] ? p1_din  : p2_din);
    grant_rnw  = grant_oh[0] ? p0_rnw  : (grant_oh[1] ? p1_rnw  : p2_rnw);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_oh      <= 3'b000;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= 8'h00;
      mem_rnw     <= 1'b1;
      tmo_cnt     <= 8'd0;
      burst_cnt   <= '0;
      rr_p2       <= 1'b0;
      done        <= 3'b000;
      timeout_err <= 1'b0;
      for (int i = 0; i < 3; i++) dout[i] <= 8'hFF;
    end else begin
      done <= 3'b000;
      if (grant) begin
        sel_oh   <= grant_oh;
        mem_req  <= 1'b1;
        mem_addr <= grant_addr;
        mem_din  <= grant_din;
        mem_rnw  <= grant_rnw;
        // Counts the ISSUE entry cycle, so the abort lands TIMEOUT cycles after the grant decision
        tmo_cnt  <= 8'd1;
        if (grant_oh[0]) begin
          burst_cnt <= bg_pend ? burst_cnt + 1'b1 : '0;
        end else begin
          burst_cnt <= '0;
          rr_p2     <= grant_oh[1];
        end
      end else begin
        if (!bg_pend) burst_cnt <= '0;
        tmo_cnt <= (state != IDLE) ? tmo_cnt + 8'd1 : 8'd0;
      end
      if ((state == ISSUE) && (mem_ack || abort)) mem_req <= 1'b0;
      if (finish || abort) begin
        done <= sel_oh;
        for (int i = 0; i < 3; i++) begin
          if (sel_oh[i] && mem_rnw) dout[i] <= finish ? mem_dout : 8'hFF;
        end
        if (abort) timeout_err <= 1'b1;
      end
    end
  end

  assign p0_done = done[0];
  assign p1_done = done[1];
  assign p2_done = done[2];
  assign p0_dout = dout[0];
  assign p1_dout = dout[1];
  assign p2_dout = dout[2];

endmodule

`default_nettype wire

// File: tb/tb_msx_ram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_msx_ram_port_arbiter: directed scenarios plus randomized traffic.     |
// |                                                     Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_msx_ram_port_arbiter;

  localparam int AW        = 27;
  localparam int CPU_BURST = 4;
  localparam int TIMEOUT   = 255;
  localparam int LW        = AW - 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    req_v;
  logic [AW-1:0] addr_a [3];
  logic [7:0]    din_a [3];
  logic [2:0]    rnw_v;
  logic          p0_done, p1_done, p2_done;
  logic [7:0]    p0_dout, p1_dout, p2_dout;
  logic          mem_req, mem_rnw, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_ack, mem_done;
  logic [7:0]    mem_dout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  msx_ram_port_arbiter #(.AW(AW), .CPU_BURST(CPU_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(req_v[0]), .p0_addr(addr_a[0]), .p0_din(din_a[0]), .p0_rnw(rnw_v[0]),
    .p0_done(p0_done), .p0_dout(p0_dout),
    .p1_req(req_v[1]), .p1_addr(addr_a[1]), .p1_din(din_a[1]), .p1_rnw(rnw_v[1]),
    .p1_done(p1_done), .p1_dout(p1_dout),
    .p2_req(req_v[2]), .p2_addr(addr_a[2]), .p2_din(din_a[2]), .p2_rnw(rnw_v[2]),
    .p2_done(p2_done), .p2_dout(p2_dout),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_rnw(mem_rnw),
    .mem_ack(mem_ack), .mem_done(mem_done), .mem_dout(mem_dout),
    .timeout_err(timeout_err)
  );

  function automatic logic [7:0] dout_of(input int k);
    case (k)
      0:       return p0_dout;
      1:       return p1_dout;
      default: return p2_dout;
    endcase
  endfunction

  task automatic do_reset();
    req_v    = 3'b000;
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    mem_dout = 8'h00;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req_v = 3'b000; mem_ack = 1'b0; mem_done = 1'b0; mem_dout = 8'h00;
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_rnw, timeout_err} !== 3'b010) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 010", {mem_req, mem_rnw, timeout_err});
    end
    vectors++;
    if (mem_addr !== '0 || mem_din !== 8'h00) begin
      miscompares++; $display("FAIL reset_bus: got addr %h din %h want 0/0", mem_addr, mem_din);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({p2_done, p1_done, p0_done} !== 3'b000) begin
      miscompares++; $display("FAIL reset_done: got %b want 000", {p2_done, p1_done, p0_done});
    end
    vectors++;
    if ({p0_dout, p1_dout, p2_dout} !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL reset_dout: got %h want ffffff", {p0_dout, p1_dout, p2_dout});
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);                       // cycle 0
    addr_a[0] = 27'h0001234; rnw_v[0] = 1'b1; din_a[0] = 8'h00; req_v[0] = 1'b1;
    @(negedge clk);                       // cycle 1
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 27'h0001234 || mem_rnw !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_issue: got req %b addr %h rnw %b want 1 0001234 1", mem_req, mem_addr, mem_rnw);
    end
    @(negedge clk);                       // cycle 2
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++; $display("FAIL rd_req_hold: got %b want 1", mem_req);
    end
    mem_ack = 1'b1;
    @(negedge clk);                       // cycle 3
    mem_ack = 1'b0; mem_done = 1'b1; mem_dout = 8'h5A;
    vectors++;
    if (mem_req !== 1'b0 || p0_done !== 1'b0) begin
      miscompares++; $display("FAIL rd_wait: got req %b done %b want 0 0", mem_req, p0_done);
    end
    @(negedge clk);                       // cycle 4
    mem_done = 1'b0;
    vectors++;
    if (p0_done !== 1'b1 || p0_dout !== 8'h5A) begin
      miscompares++; $display("FAIL rd_done: got done %b dout %h want 1 5a", p0_done, p0_dout);
    end
    req_v[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (p0_done !== 1'b0 || p0_dout !== 8'h5A || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_after: got done %b dout %h req %b want 0 5a 0", p0_done, p0_dout, mem_req);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    addr_a[1] = 27'h10; din_a[1] = 8'hC3; rnw_v[1] = 1'b0; req_v[1] = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 27'h10 || mem_din !== 8'hC3 || mem_rnw !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_issue: got req %b addr %h din %h rnw %b want 1 10 c3 0",
               mem_req, mem_addr, mem_din, mem_rnw);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_done = 1'b1; mem_dout = 8'h77;
    @(negedge clk);
    mem_done = 1'b0;
    vectors++;
    if ({p2_done, p1_done, p0_done} !== 3'b010 || p1_dout !== 8'hFF) begin
      miscompares++;
      $display("FAIL wr_done: got done %b dout %h want 010 ff", {p2_done, p1_done, p0_done}, p1_dout);
    end
    req_v[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (p1_done !== 1'b0 || mem_din !== 8'hC3 || mem_rnw !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_after: got done %b din %h rnw %b want 0 c3 0", p1_done, mem_din, mem_rnw);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    addr_a[2] = 27'h7ABCDE; rnw_v[2] = 1'b1; din_a[2] = 8'h00; req_v[2] = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 27'h7ABCDE) begin
      miscompares++; $display("FAIL sc_issue: got req %b addr %h want 1 7abcde", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_done = 1'b1; mem_dout = 8'hA5;
    @(negedge clk);
    mem_ack = 1'b0; mem_done = 1'b0;
    vectors++;
    if (p2_done !== 1'b1 || p2_dout !== 8'hA5 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL sc_done: got done %b dout %h req %b want 1 a5 0", p2_done, p2_dout, mem_req);
    end
    req_v[2] = 1'b0;
    @(negedge clk);
    vectors++;
    if (p2_done !== 1'b0) begin
      miscompares++; $display("FAIL sc_single: got done %b want 0", p2_done);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    @(negedge clk);                       // cycle 0
    addr_a[2] = 27'h55; rnw_v[2] = 1'b1; req_v[2] = 1'b1;
    for (int c = 1; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || p2_done !== 1'b0 || timeout_err !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL to_wait: got %0d bad cycles want 0", bad);
    end
    @(negedge clk);                       // cycle TIMEOUT
    vectors++;
    if (mem_req !== 1'b0 || p2_done !== 1'b1 || p2_dout !== 8'hFF || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_abort: got req %b done %b dout %h err %b want 0 1 ff 1",
               mem_req, p2_done, p2_dout, timeout_err);
    end
    req_v[2] = 1'b0;
    mem_ack = 1'b1; mem_done = 1'b1; mem_dout = 8'h33;
    @(negedge clk);
    mem_ack = 1'b0; mem_done = 1'b0;
    vectors++;
    if (p2_done !== 1'b0 || p2_dout !== 8'hFF || mem_req !== 1'b0 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_late: got done %b dout %h req %b err %b want 0 ff 0 1",
               p2_done, p2_dout, mem_req, timeout_err);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    addr_a[0] = 27'h2A5; rnw_v[0] = 1'b1; req_v[0] = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);                       // WAIT_DONE
    mem_ack = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_rnw, timeout_err} !== 3'b010 || mem_addr !== '0) begin
      miscompares++;
      $display("FAIL ar_ctl: got req %b rnw %b err %b addr %h want 0 1 0 0",
               mem_req, mem_rnw, timeout_err, mem_addr);
    end
    vectors++;
    if ({p0_dout, p1_dout, p2_dout} !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL ar_dout: got %h want ffffff", {p0_dout, p1_dout, p2_dout});
    end
    req_v[0] = 1'b0; mem_done = 1'b1; mem_dout = 8'h11;
    @(negedge clk);
    mem_done = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({p2_done, p1_done, p0_done} !== 3'b000 || p0_dout !== 8'hFF) begin
      miscompares++;
      $display("FAIL ar_nodone: got done %b dout %h want 000 ff", {p2_done, p1_done, p0_done}, p0_dout);
    end
    addr_a[1] = 27'h4321; rnw_v[1] = 1'b1; req_v[1] = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 27'h4321) begin
      miscompares++; $display("FAIL ar_next_issue: got req %b addr %h want 1 4321", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_done = 1'b1; mem_dout = 8'h6E;
    @(negedge clk);
    mem_ack = 1'b0; mem_done = 1'b0;
    vectors++;
    if (p1_done !== 1'b1 || p1_dout !== 8'h6E) begin
      miscompares++; $display("FAIL ar_next_done: got done %b dout %h want 1 6e", p1_done, p1_dout);
    end
    req_v[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int got_order [10];
    int n = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      addr_a[k] = {2'(k), LW'(k + 100)}; din_a[k] = 8'(k); rnw_v[k] = 1'b1;
    end
    req_v = 3'b111;
    for (int c = 0; c < 300 && n < 10; c++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_done = 1'b0;
      if (mem_req === 1'b1) begin
        got_order[n] = int'(mem_addr[AW-1 -: 2]);
        n++;
        mem_ack = 1'b1; mem_done = 1'b1; mem_dout = 8'($urandom);
      end
    end
    vectors++;
    if (n != 10) begin
      miscompares++; $display("FAIL b2b_bound: got %0d grants want 10", n);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_order[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got P%0d want P%0d", i, got_order[i], exp_order[i]);
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_done = 1'b0; req_v = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int bursts = 0;
    int rr = 1;
    bit active = 1'b0;
    bit drained = 1'b0;
    int aport = 0;
    int ack_at = 0, done_at = 0, dcyc = -1;
    int exp;
    int gap [3];
    logic [7:0] rdata = 8'h00;
    logic [7:0] exp_dout [3];
    logic [2:0] snap, expdone;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      gap[k] = $urandom_range(0, 3);
      exp_dout[k] = 8'hFF;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      snap = req_v;
      expdone = (active && cyc == dcyc) ? 3'(1 << aport) : 3'b000;
      vectors++;
      if ({p2_done, p1_done, p0_done} !== expdone) begin
        miscompares++;
        $display("FAIL rnd_done@%0d: got %b want %b", cyc, {p2_done, p1_done, p0_done}, expdone);
      end
      if (expdone != 3'b000) begin
        if (rnw_v[aport]) exp_dout[aport] = rdata;
        vectors++;
        if (dout_of(aport) !== exp_dout[aport]) begin
          miscompares++;
          $display("FAIL rnd_dout@%0d: P%0d got %h want %h", cyc, aport, dout_of(aport), exp_dout[aport]);
        end
        req_v[aport] = 1'b0;
        gap[aport] = $urandom_range(0, 4);
        active = 1'b0;
      end
      if (active) begin
        vectors++;
        if (mem_req !== (cyc <= ack_at)) begin
          miscompares++;
          $display("FAIL rnd_req@%0d: got %b want %b", cyc, mem_req, (cyc <= ack_at));
        end
      end else if (mem_req === 1'b1) begin
        // Arbitration rules applied to the requests the arbiter sampled last cycle
        if (snap[0] && !(bursts == CPU_BURST && (snap[1] || snap[2]))) begin
          exp = 0;
          bursts = (snap[1] || snap[2]) ? bursts + 1 : 0;
        end else begin
          if (rr == 1) exp = snap[1] ? 1 : 2;
          else         exp = snap[2] ? 2 : 1;
          rr = (exp == 1) ? 2 : 1;
          bursts = 0;
        end
        vectors++;
        if (int'(mem_addr[AW-1 -: 2]) != exp) begin
          miscompares++;
          $display("FAIL rnd_grant@%0d: got P%0d want P%0d", cyc, mem_addr[AW-1 -: 2], exp);
        end
        vectors++;
        if ({mem_addr, mem_din, mem_rnw} !== {addr_a[exp], din_a[exp], rnw_v[exp]}) begin
          miscompares++;
          $display("FAIL rnd_bus@%0d: got %h/%h/%b want %h/%h/%b", cyc, mem_addr, mem_din, mem_rnw,
                   addr_a[exp], din_a[exp], rnw_v[exp]);
        end
        active  = 1'b1;
        aport   = exp;
        ack_at  = cyc + $urandom_range(0, 3);
        done_at = ack_at + $urandom_range(0, 3);
        dcyc    = done_at + 1;
        rdata   = 8'($urandom);
      end
      mem_ack  = active && (cyc == ack_at);
      mem_done = active && (cyc == done_at);
      mem_dout = mem_done ? rdata : 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        if (!req_v[k] && cyc < 3000) begin
          if (gap[k] == 0) begin
            addr_a[k] = {2'(k), LW'($urandom)};
            din_a[k]  = 8'($urandom);
            rnw_v[k]  = 1'($urandom);
            req_v[k]  = 1'b1;
          end else begin
            gap[k]--;
          end
        end
      end
      if (cyc >= 3000 && !active && req_v == 3'b000) begin
        drained = 1'b1;
        break;
      end
    end
    vectors++;
    if (!drained) begin
      miscompares++; $display("FAIL rnd_drain: got pending %b active %b want idle", req_v, active);
    end
    mem_ack = 1'b0; mem_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_v = 3'b000; rnw_v = 3'b111; mem_ack = 1'b0; mem_done = 1'b0; mem_dout = 8'h00;
    for (int k = 0; k < 3; k++) begin
      addr_a[k] = '0; din_a[k] = 8'h00;
    end
    test_reset();
    test_single_read();
    test_write();
    test_same_cycle();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
